dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 64, number of 32-bit memory words (power of two).
REQ-002 SHALL provide parameter WAIT_CYCLES, default 2, extra wait states per transaction (used only with DMEM_WAIT_EN).
REQ-003 SHALL provide port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port req_valid  input  1  core presents a load/store request.
REQ-006 SHALL provide port req_ready  output  1  responder can accept a request.
REQ-007 SHALL provide port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL provide port req_addr  input  32  byte address.
REQ-009 SHALL provide port req_funct3  input  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-010 SHALL provide port req_wdata  input  32  store data, LSB-aligned.
REQ-011 SHALL provide port rsp_valid  output  1  response available.
REQ-012 SHALL provide port rsp_ready  input  1  core accepts the response.
REQ-013 SHALL provide port rsp_rdata  output  32  load data, extended per funct3; 0 for stores and errors.
REQ-014 SHALL provide port rsp_err  output  1  misaligned access or illegal funct3.

Function
REQ-015 SHALL implement the FSM IDLE -> (WAIT) -> RESP -> IDLE; only IDLE asserts req_ready.
REQ-016 SHALL accept a request when req_valid && req_ready, latching we, addr, funct3 and wdata on that edge.
REQ-017 SHALL use word index addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored (wrap modulo DEPTH_WORDS*4).
REQ-018 SHALL flag an error for a halfword access with addr[0]=1, a word access with addr[1:0]!=0, or funct3 in {011,110,111}, or funct3 in {100,101} with we=1.
REQ-019 SHALL commit a store, using byte lanes selected by addr[1:0] and width, on the edge that enters RESP; an erroring store SHALL leave memory unchanged.
REQ-020 SHALL capture load data on the edge entering RESP: byte/halfword selected by addr[1:0], sign-extended for 000/001, zero-extended for 100/101.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-022 SHALL NOT accept a new request in the cycle the response handshake completes (req_ready rises the following cycle).
REQ-023 SHALL ignore req_* inputs while not in IDLE.

Reset
REQ-024 SHALL on rst=1 immediately enter IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
REQ-025 SHALL abort any in-flight transaction on reset; a store not yet committed SHALL NOT be written.
REQ-026 SHALL NOT clear memory contents on reset.

Configuration
REQ-027 SHALL with macro DMEM_WAIT_EN defined pass through WAIT for exactly WAIT_CYCLES cycles (WAIT_CYCLES=0 skips WAIT), giving accept-to-rsp_valid latency of WAIT_CYCLES+1 cycles.
REQ-028 SHALL without DMEM_WAIT_EN omit WAIT state and counter: rsp_valid asserts the cycle after accept (latency 1).

Verification
REQ-029 SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-030 SB 0x80 @0x13 over 0x00000000, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80000000.
REQ-031 LH @0x11 -> rsp_err=1, rsp_rdata=0; SW 0x12345678 @0x22 -> rsp_err=1, LW @0x20 unchanged.
REQ-032 LW with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; release -> IDLE next edge.
REQ-033 DMEM_WAIT_EN, WAIT_CYCLES=2: accept at cycle N -> rsp_valid first high at N+3; rst pulsed at N+1 during SW -> memory unchanged, req_ready=1.
REQ-034 SW 0xA5A5A5A5 @0x100 with DEPTH_WORDS=64 -> LW @0x000 returns 0xA5A5A5A5 (address wrap).

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data memory responder for an RV32I load/store unit (valid/ready request and response).
// Optional wait states are enabled by defining DMEM_WAIT_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

`ifdef DMEM_WAIT_EN
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  logic [CW-1:0] wait_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_RESP} state_t;
`endif

  state_t state, state_nx;

  logic [31:0] mem [DEPTH_WORDS];

  logic          lat_we;
  logic [AW+1:0] lat_addr;
  logic [2:0]    lat_f3;
  logic [31:0]   lat_wdata;

  logic          accept, enter_resp;
  logic          cur_we, cur_err;
  logic [AW+1:0] cur_addr;
  logic [2:0]    cur_f3;
  logic [31:0]   cur_wdata;
  logic [AW-1:0] cur_idx;
  logic [1:0]    cur_off;
  logic [3:0]    be;
  logic [31:0]   wd_lanes, word, shifted, load_data;

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+2];

  assign accept = req_valid && req_ready;

  // The committing edge may be the accept edge itself, so operands come straight
  // from the request port while idle and from the latched copy otherwise.
  assign cur_we    = (state == S_IDLE) ? req_we              : lat_we;
  assign cur_addr  = (state == S_IDLE) ? req_addr[AW+1:0]    : lat_addr;
  assign cur_f3    = (state == S_IDLE) ? req_funct3          : lat_f3;
  assign cur_wdata = (state == S_IDLE) ? req_wdata           : lat_wdata;
  assign cur_idx   = cur_addr[AW+1:2];
  assign cur_off   = cur_addr[1:0];

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
`ifdef DMEM_WAIT_EN
          if (WAIT_CYCLES == 0) begin
            state_nx   = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = S_WAIT;
          end
`else
          state_nx   = S_RESP;
          enter_resp = 1'b1;
`endif
        end
      end
`ifdef DMEM_WAIT_EN
      S_WAIT: begin
        if (wait_cnt == CW'(WAIT_CYCLES - 1)) begin
          state_nx   = S_RESP;
          enter_resp = 1'b1;
        end
      end
`endif
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cur_err = 1'b0;
    case (cur_f3)
      3'b000:  cur_err = 1'b0;
      3'b001:  cur_err = cur_off[0];
      3'b010:  cur_err = (cur_off != 2'b00);
      3'b100:  cur_err = cur_we;
      3'b101:  cur_err = cur_we || cur_off[0];
      default: cur_err = 1'b1;
    endcase
  end

  always_comb begin
    be       = 4'b0000;
    wd_lanes = cur_wdata;
    case (cur_f3)
      3'b000: begin
        be       = 4'b0001 << cur_off;
        wd_lanes = {4{cur_wdata[7:0]}};
      end
      3'b001: begin
        be       = cur_off[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{cur_wdata[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    word      = mem[cur_idx];
    shifted   = word >> {cur_off, 3'b000};
    load_data = '0;
    case (cur_f3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = word;
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

  // Gated by rst so a store racing an asserted reset never lands.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !cur_err && !rst) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[cur_idx][8*b +: 8] <= wd_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_f3    <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef DMEM_WAIT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr[AW+1:0];
        lat_f3    <= req_funct3;
        lat_wdata <= req_wdata;
      end
      if (enter_resp) begin
        rsp_err   <= cur_err;
        rsp_rdata <= (cur_we || cur_err) ? '0 : load_data;
      end
`ifdef DMEM_WAIT_EN
      if (accept)               wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
`endif
    end
  end

endmodule
